// File: rtl/serial_slave_split_pkg.sv
// Shared definitions for the bit-serial bus slave: response codes, FSM states and
// counter sizing.
package serial_slave_split_pkg;

    typedef enum logic [1:0] {
        RespWait  = 2'b00,
        RespOkay  = 2'b01,
        RespSplit = 2'b10,
        RespError = 2'b11
    } resp_e;

    typedef enum logic [2:0] {
        StIdle,
        StAddr,
        StWdata,
        StWresp,
        StRwait,
        StRdata,
        StSplitPend,
        StErr
    } state_e;

    // Wide enough for READ_LATENCY + 1 with READ_LATENCY up to 255.
    localparam int unsigned CntW = 9;

endpackage

// File: rtl/serial_slave_split_if.sv
// Bus-side signals seen by a serial slave: strobe, direction, serial address/data lines
// and the arbiter/decoder results.
interface serial_slave_split_if
    import serial_slave_split_pkg::*;
#(
    parameter int unsigned MID_W = 2
) ();

    logic             addr_valid;
    logic             rw;
    logic             address_bus;
    logic             w_data_bus;
    logic [MID_W-1:0] granted_master;
    logic [1:0]       slave_address;

    modport master (
        output addr_valid, rw, address_bus, w_data_bus, granted_master, slave_address
    );

    modport slave (
        input addr_valid, rw, address_bus, w_data_bus, granted_master, slave_address
    );

endinterface

// File: rtl/serial_slave_split_ram.sv
// Single-port synchronous RAM: write on the clock edge, one-cycle registered read whose
// output register is cleared by reset.
module serial_slave_split_ram
    import serial_slave_split_pkg::*;
#(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned MEM_DEPTH = 4096,
    parameter int unsigned AW        = 12
) (
    input  logic              clock50,
    input  logic              reset,
    input  logic              we,
    input  logic              re,
    input  logic [AW-1:0]     addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [MEM_DEPTH];

    always_ff @(posedge clock50) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    always_ff @(posedge clock50) begin
        if (reset) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/serial_slave_split.sv
// Bit-serial bus slave with on-chip RAM, range-checked addressing, programmable read
// latency and split reads that release the bus while the read completes.
module serial_slave_split
    import serial_slave_split_pkg::*;
#(
    parameter int unsigned SLAVE_ID        = 0,
    parameter int unsigned ADDR_W          = 12,
    parameter int unsigned DATA_W          = 8,
    parameter int unsigned MEM_DEPTH       = 4096,
    parameter int unsigned NUM_MASTERS     = 2,
    parameter int unsigned MID_W           = 2,
    parameter int unsigned READ_LATENCY    = 4,
    parameter int unsigned SPLIT_EN        = 1,
    parameter int unsigned SPLIT_THRESHOLD = 2
) (
    input  logic                   clock50,
    input  logic                   reset,
    serial_slave_split_if.slave    bus,
    output tri                     r_data_bus,
    output tri [1:0]               response_bus,
    output logic [NUM_MASTERS-1:0] split_request
);

    localparam int unsigned AW      = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam int unsigned MaxBits = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
    localparam int unsigned BitW    = $clog2(MaxBits + 1);
    localparam bit          SplitMode = (SPLIT_EN != 0) && (READ_LATENCY > SPLIT_THRESHOLD);

    state_e            state_q;
    resp_e             resp_q;
    logic              drive_q;
    logic              r_bit_q;
    logic              rw_q;
    logic              req_q;
    logic [MID_W-1:0]  owner_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rsh_q;
    logic [BitW-1:0]   bit_cnt_q;
    logic [CntW-1:0]   lat_cnt_q;

    logic [ADDR_W-1:0]      addr_full;
    logic                   in_range;
    logic                   addr_last;
    logic                   owner_ok;
    logic                   sel;
    logic                   ram_we;
    logic                   ram_re;
    logic [AW-1:0]          ram_addr;
    logic [DATA_W-1:0]      ram_rdata;
    logic [NUM_MASTERS-1:0] owner_hot;
    logic [1:0]             resp_bits;

    always_comb begin
        addr_full = {bus.address_bus, addr_q[ADDR_W-1:1]};
        in_range  = 32'(addr_full) < 32'(MEM_DEPTH);
        addr_last = (state_q == StAddr) && (bit_cnt_q == BitW'(ADDR_W - 1));
        owner_ok  = 32'(owner_q) < 32'(NUM_MASTERS);
        sel       = bus.slave_address == 2'(SLAVE_ID);
        ram_we    = state_q == StWresp;
        // Read is launched on the last address edge so data is ready for the first wait cycle.
        ram_re    = addr_last && !rw_q && in_range;
        ram_addr  = ram_we ? addr_q[AW-1:0] : addr_full[AW-1:0];
        resp_bits = resp_q;
        owner_hot = '0;
        for (int i = 0; i < int'(NUM_MASTERS); i++) begin
            owner_hot[i] = owner_q == MID_W'(i);
        end
    end

    serial_slave_split_ram #(
        .DATA_W    (DATA_W),
        .MEM_DEPTH (MEM_DEPTH),
        .AW        (AW)
    ) u_ram (
        .clock50 (clock50),
        .reset   (reset),
        .we      (ram_we),
        .re      (ram_re),
        .addr    (ram_addr),
        .wdata   (wdata_q),
        .rdata   (ram_rdata)
    );

    always_ff @(posedge clock50) begin
        if (reset) begin
            state_q       <= StIdle;
            resp_q        <= RespWait;
            drive_q       <= 1'b0;
            r_bit_q       <= 1'b0;
            rw_q          <= 1'b0;
            req_q         <= 1'b0;
            owner_q       <= '0;
            addr_q        <= '0;
            wdata_q       <= '0;
            rsh_q         <= '0;
            bit_cnt_q     <= '0;
            lat_cnt_q     <= '0;
            split_request <= '0;
        end else begin
            // Bus is released unless a state below claims it for the next cycle.
            drive_q <= 1'b0;
            resp_q  <= RespWait;
            r_bit_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (bus.addr_valid && sel) begin
                        rw_q      <= bus.rw;
                        owner_q   <= bus.granted_master;
                        addr_q    <= addr_full;
                        bit_cnt_q <= BitW'(1);
                        state_q   <= StAddr;
                    end
                end
                StAddr: begin
                    addr_q    <= addr_full;
                    bit_cnt_q <= bit_cnt_q + 1'b1;
                    if (addr_last) begin
                        bit_cnt_q <= '0;
                        if (!in_range) begin
                            drive_q <= 1'b1;
                            resp_q  <= RespError;
                            state_q <= StErr;
                        end else if (rw_q) begin
                            state_q <= StWdata;
                        end else if (SplitMode) begin
                            drive_q <= 1'b1;
                            if (owner_ok) begin
                                resp_q    <= RespSplit;
                                req_q     <= 1'b0;
                                lat_cnt_q <= CntW'(READ_LATENCY + 1);
                                state_q   <= StSplitPend;
                            end else begin
                                resp_q  <= RespError;
                                state_q <= StErr;
                            end
                        end else begin
                            drive_q   <= 1'b1;
                            resp_q    <= RespWait;
                            lat_cnt_q <= CntW'(READ_LATENCY);
                            state_q   <= StRwait;
                        end
                    end
                end
                StWdata: begin
                    wdata_q   <= {bus.w_data_bus, wdata_q[DATA_W-1:1]};
                    bit_cnt_q <= bit_cnt_q + 1'b1;
                    if (bit_cnt_q == BitW'(DATA_W - 1)) begin
                        bit_cnt_q <= '0;
                        drive_q   <= 1'b1;
                        resp_q    <= RespOkay;
                        state_q   <= StWresp;
                    end
                end
                StWresp: begin
                    state_q <= StIdle;
                end
                StRwait: begin
                    drive_q <= 1'b1;
                    if (lat_cnt_q == '0) begin
                        resp_q    <= RespOkay;
                        r_bit_q   <= ram_rdata[0];
                        rsh_q     <= {1'b0, ram_rdata[DATA_W-1:1]};
                        bit_cnt_q <= '0;
                        state_q   <= StRdata;
                    end else begin
                        resp_q    <= RespWait;
                        lat_cnt_q <= lat_cnt_q - 1'b1;
                    end
                end
                StRdata: begin
                    if (bit_cnt_q == BitW'(DATA_W - 1)) begin
                        state_q <= StIdle;
                    end else begin
                        drive_q   <= 1'b1;
                        resp_q    <= RespOkay;
                        r_bit_q   <= rsh_q[0];
                        rsh_q     <= {1'b0, rsh_q[DATA_W-1:1]};
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                    end
                end
                StSplitPend: begin
                    // Another master addressing us while the split is outstanding is refused.
                    if (bus.addr_valid && sel && (bus.granted_master != owner_q)) begin
                        drive_q <= 1'b1;
                        resp_q  <= RespError;
                    end
                    if (!req_q) begin
                        if (lat_cnt_q == '0) begin
                            req_q         <= 1'b1;
                            split_request <= owner_hot;
                            rsh_q         <= ram_rdata;
                        end else begin
                            lat_cnt_q <= lat_cnt_q - 1'b1;
                        end
                    end else if (sel && (bus.granted_master == owner_q)) begin
                        req_q         <= 1'b0;
                        split_request <= '0;
                        drive_q       <= 1'b1;
                        resp_q        <= RespOkay;
                        r_bit_q       <= rsh_q[0];
                        rsh_q         <= {1'b0, rsh_q[DATA_W-1:1]};
                        bit_cnt_q     <= '0;
                        state_q       <= StRdata;
                    end
                end
                StErr: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    bufif1 u_rdata_drv (r_data_bus, r_bit_q, drive_q);
    bufif1 u_resp0_drv (response_bus[0], resp_bits[0], drive_q);
    bufif1 u_resp1_drv (response_bus[1], resp_bits[1], drive_q);

endmodule

// File: tb/tb_serial_slave_split.sv
// Two slaves on one serial bus: slave 0 is non-split with a short latency and a half-size
// RAM, slave 1 splits long reads. Expectations come from per-slave word models.
module tb_serial_slave_split;

    localparam int unsigned A_DEPTH = 2048;
    localparam int unsigned A_LAT   = 1;
    localparam int unsigned B_DEPTH = 4096;
    localparam int unsigned B_LAT   = 6;

    localparam logic [1:0] R_WAIT  = 2'b00;
    localparam logic [1:0] R_OKAY  = 2'b01;
    localparam logic [1:0] R_SPLIT = 2'b10;
    localparam logic [1:0] R_ERROR = 2'b11;

    logic clock50 = 1'b0;
    logic reset   = 1'b1;
    int   errors  = 0;
    int   checks  = 0;

    logic [7:0] mem_a [int];
    logic [7:0] mem_b [int];

    serial_slave_split_if #(.MID_W(2)) bus ();

    tri       rdat_a;
    tri       rdat_b;
    tri [1:0] resp_a;
    tri [1:0] resp_b;
    logic [1:0] split_a;
    logic [1:0] split_b;

    wire a_z = (rdat_a === 1'bz) && (resp_a === 2'bzz);
    wire b_z = (rdat_b === 1'bz) && (resp_b === 2'bzz);

    always #5 clock50 = ~clock50;

    serial_slave_split #(
        .SLAVE_ID (0), .ADDR_W (12), .DATA_W (8), .MEM_DEPTH (A_DEPTH), .NUM_MASTERS (2),
        .MID_W (2), .READ_LATENCY (A_LAT), .SPLIT_EN (0), .SPLIT_THRESHOLD (2)
    ) dut_a (
        .clock50 (clock50), .reset (reset), .bus (bus), .r_data_bus (rdat_a),
        .response_bus (resp_a), .split_request (split_a)
    );

    serial_slave_split #(
        .SLAVE_ID (1), .ADDR_W (12), .DATA_W (8), .MEM_DEPTH (B_DEPTH), .NUM_MASTERS (2),
        .MID_W (2), .READ_LATENCY (B_LAT), .SPLIT_EN (1), .SPLIT_THRESHOLD (2)
    ) dut_b (
        .clock50 (clock50), .reset (reset), .bus (bus), .r_data_bus (rdat_b),
        .response_bus (resp_b), .split_request (split_b)
    );

    task automatic cyc();
        @(negedge clock50);
    endtask

    task automatic idle_bus();
        bus.addr_valid     = 1'b0;
        bus.rw             = 1'b0;
        bus.address_bus    = 1'b0;
        bus.w_data_bus     = 1'b0;
        bus.granted_master = 2'd0;
        bus.slave_address  = 2'd3;
    endtask

    // Serialises the address; the first cycle also confirms the slave is idle.
    task automatic send_addr(input int sid, input logic [1:0] owner, input logic rw,
                             input logic [11:0] addr);
        for (int i = 0; i < 12; i++) begin
            cyc();
            if (i == 0) begin
                checks++;
                if (!(sid == 0 ? a_z : b_z)) begin
                    errors++;
                    $display("FAIL idle_before_select sid=%0d: bus driven, required Z", sid);
                end
            end
            bus.addr_valid     = (i == 0);
            bus.rw             = rw;
            bus.slave_address  = 2'(sid);
            bus.granted_master = owner;
            bus.address_bus    = addr[i];
        end
    endtask

    task automatic do_write(input int sid, input logic [1:0] owner, input logic [11:0] addr,
                            input logic [7:0] data);
        logic [1:0] r;
        int unsigned depth;
        depth = (sid == 0) ? A_DEPTH : B_DEPTH;
        send_addr(sid, owner, 1'b1, addr);
        if (addr >= depth) begin
            cyc();
            r = (sid == 0) ? resp_a : resp_b;
            checks++;
            if (r !== R_ERROR || (sid == 0 ? a_z : b_z)) begin
                errors++;
                $display("FAIL write_range_error addr=%h: resp=%b, required %b", addr, r, R_ERROR);
            end
            idle_bus();
            return;
        end
        for (int i = 0; i < 8; i++) begin
            cyc();
            bus.addr_valid = 1'b0;
            bus.w_data_bus = data[i];
            if (i == 0) begin
                checks++;
                if (!(sid == 0 ? a_z : b_z)) begin
                    errors++;
                    $display("FAIL write_data_phase_z addr=%h: bus driven, required Z", addr);
                end
            end
        end
        cyc();
        idle_bus();
        r = (sid == 0) ? resp_a : resp_b;
        checks++;
        if (r !== R_OKAY || (sid == 0 ? rdat_a : rdat_b) !== 1'b0) begin
            errors++;
            $display("FAIL write_okay addr=%h: resp=%b, required %b", addr, r, R_OKAY);
        end
        if (sid == 0) mem_a[int'(addr)] = data;
        else          mem_b[int'(addr)] = data;
    endtask

    task automatic do_read_a(input logic [11:0] addr);
        logic [7:0] got;
        logic       ok_all;
        send_addr(0, 2'd0, 1'b0, addr);
        if (addr >= A_DEPTH) begin
            cyc();
            idle_bus();
            checks++;
            if (resp_a !== R_ERROR || a_z) begin
                errors++;
                $display("FAIL read_range_error addr=%h: resp=%b, required %b", addr, resp_a,
                         R_ERROR);
            end
            return;
        end
        for (int i = 0; i < int'(A_LAT) + 1; i++) begin
            cyc();
            idle_bus();
            checks++;
            if (a_z || resp_a !== R_WAIT || rdat_a !== 1'b0) begin
                errors++;
                $display("FAIL read_wait addr=%h cycle %0d: resp=%b, required %b", addr, i, resp_a,
                         R_WAIT);
            end
        end
        ok_all = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cyc();
            if (a_z || resp_a !== R_OKAY) ok_all = 1'b0;
            got[i] = rdat_a;
        end
        checks++;
        if (!ok_all) begin
            errors++;
            $display("FAIL read_okay addr=%h: OKAY missing during data, required 8 OKAY cycles",
                     addr);
        end
        checks++;
        if (got !== mem_a[int'(addr)]) begin
            errors++;
            $display("FAIL read_data addr=%h: got %h, required %h", addr, got, mem_a[int'(addr)]);
        end
    endtask

    task automatic test_reset();
        idle_bus();
        reset = 1'b1;
        repeat (3) cyc();
        checks++;
        if (!a_z || !b_z || split_a !== 2'b00 || split_b !== 2'b00) begin
            errors++;
            $display("FAIL reset_state: a_z=%b b_z=%b split_a=%b split_b=%b, required Z and 00",
                     a_z, b_z, split_a, split_b);
        end
        reset = 1'b0;
        cyc();
    endtask

    task automatic test_write_read();
        do_write(0, 2'd0, 12'h010, 8'hA5);
        do_read_a(12'h010);
    endtask

    task automatic test_range();
        logic [7:0] d;
        d = 8'($urandom);
        do_write(0, 2'd0, 12'h123, d);
        do_write(0, 2'd0, 12'h923, ~d);   // aliases 0x123 if the range check were missing
        do_read_a(12'h123);
        do_read_a(12'hFFF);
        do_write(0, 2'd0, 12'h7FF, 8'($urandom));
        do_read_a(12'h7FF);
        do_read_a(12'h800);
    endtask

    task automatic test_back_to_back();
        do_write(0, 2'd0, 12'h000, 8'h11);
        do_write(0, 2'd0, 12'h001, 8'h22);
        do_read_a(12'h000);
        do_read_a(12'h001);
    endtask

    task automatic test_split(input logic [11:0] addr, input logic [7:0] data);
        logic [7:0] got;
        logic       ok_all;
        int         hold;
        do_write(1, 2'd1, addr, data);
        send_addr(1, 2'd1, 1'b0, addr);
        cyc();
        idle_bus();
        checks++;
        if (resp_b !== R_SPLIT || b_z) begin
            errors++;
            $display("FAIL split_response: resp=%b, required %b", resp_b, R_SPLIT);
        end
        for (int i = 1; i <= int'(B_LAT) + 1; i++) begin
            cyc();
            checks++;
            if (i == 4) begin
                if (resp_b !== R_ERROR || b_z || split_b !== 2'b00) begin
                    errors++;
                    $display("FAIL busy_select_error: resp=%b split=%b, required %b and 00",
                             resp_b, split_b, R_ERROR);
                end
            end else if (!b_z || split_b !== 2'b00) begin
                errors++;
                $display("FAIL split_release cycle %0d: b_z=%b split=%b, required Z and 00", i,
                         b_z, split_b);
            end
            idle_bus();
            if (i == 3) begin
                bus.addr_valid    = 1'b1;
                bus.slave_address = 2'd1;
                bus.address_bus   = 1'($urandom);
            end
        end
        hold = int'($urandom_range(1, 4));
        for (int k = 0; k <= hold; k++) begin
            cyc();
            checks++;
            if (split_b !== 2'b10 || !b_z) begin
                errors++;
                $display("FAIL split_request_hold: split=%b b_z=%b, required 10 and Z", split_b,
                         b_z);
            end
            bus.granted_master = 2'($urandom_range(0, 1));
            if (k == hold) begin
                bus.granted_master = 2'd1;
                bus.slave_address  = 2'd1;
            end
        end
        ok_all = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cyc();
            idle_bus();
            if (b_z || resp_b !== R_OKAY || split_b !== 2'b00) ok_all = 1'b0;
            got[i] = rdat_b;
        end
        checks++;
        if (!ok_all) begin
            errors++;
            $display("FAIL split_resume_okay addr=%h: OKAY/request wrong, required OKAY and 00",
                     addr);
        end
        checks++;
        if (got !== mem_b[int'(addr)]) begin
            errors++;
            $display("FAIL split_data addr=%h: got %h, required %h", addr, got, mem_b[int'(addr)]);
        end
    endtask

    task automatic test_owner_error();
        send_addr(1, 2'd2, 1'b0, 12'h010);
        cyc();
        idle_bus();
        checks++;
        if (resp_b !== R_ERROR || b_z) begin
            errors++;
            $display("FAIL owner_out_of_range: resp=%b, required %b", resp_b, R_ERROR);
        end
        cyc();
        checks++;
        if (!b_z || split_b !== 2'b00) begin
            errors++;
            $display("FAIL owner_error_release: b_z=%b split=%b, required Z and 00", b_z, split_b);
        end
    endtask

    task automatic test_reset_mid_write();
        logic [7:0] prior;
        prior = 8'($urandom);
        do_write(0, 2'd0, 12'h020, prior);
        send_addr(0, 2'd0, 1'b1, 12'h020);
        for (int i = 0; i < 5; i++) begin
            cyc();
            bus.addr_valid = 1'b0;
            bus.w_data_bus = ~prior[i];
            if (i == 4) reset = 1'b1;
        end
        cyc();
        checks++;
        if (!a_z || !b_z || split_a !== 2'b00 || split_b !== 2'b00) begin
            errors++;
            $display("FAIL reset_mid_write: a_z=%b b_z=%b split_a=%b split_b=%b, required Z/00",
                     a_z, b_z, split_a, split_b);
        end
        reset = 1'b0;
        idle_bus();
        do_read_a(12'h020);
    endtask

    task automatic test_random();
        logic [11:0] addr;
        for (int n = 0; n < 6; n++) begin
            addr = 12'($urandom_range(0, A_DEPTH - 1));
            do_write(0, 2'd0, addr, 8'($urandom));
            do_read_a(addr);
        end
        test_split(12'($urandom_range(0, B_DEPTH - 1)), 8'($urandom));
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_range();
        test_back_to_back();
        test_split(12'h010, 8'h5C);
        test_owner_error();
        test_reset_mid_write();
        test_random();
        repeat (2) cyc();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
